// File: rtl/hex_frame_parser_if.sv
// Byte-in / text-key-mode-out bundle between UART receiver, parser and cipher core.
interface hex_frame_parser_if #(
    parameter int TEXT_BITS = 128,
    parameter int KEY_BITS  = 256
);
    logic                 i_rx_dv;
    logic [7:0]           i_rx_byte;
    logic [TEXT_BITS-1:0] o_text;
    logic                 o_text_valid;
    logic                 i_text_ready;
    logic [KEY_BITS-1:0]  o_key;
    logic                 o_key_valid;
    logic                 i_key_ready;
    logic                 o_decrypt;
    logic                 o_err;
    logic [1:0]           o_err_code;

    modport master (
        input  i_rx_dv,
        input  i_rx_byte,
        output o_text,
        output o_text_valid,
        input  i_text_ready,
        output o_key,
        output o_key_valid,
        input  i_key_ready,
        output o_decrypt,
        output o_err,
        output o_err_code
    );

    modport slave (
        output i_rx_dv,
        output i_rx_byte,
        input  o_text,
        input  o_text_valid,
        output i_text_ready,
        input  o_key,
        input  o_key_valid,
        output i_key_ready,
        input  o_decrypt,
        input  o_err,
        input  o_err_code
    );
endinterface

// File: rtl/hex_frame_parser.sv
// ASCII-hex M/A/E/D command parser feeding the AES-256 core.
// Define HEX_FRAME_PARSER_TIMEOUT_EN to abort frames stalled for TIMEOUT_CYCLES.
module hex_frame_parser #(
    parameter int TEXT_BITS      = 128,
    parameter int KEY_BITS       = 256,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                   clk_i,
    input  logic                   reset,
    hex_frame_parser_if.master     bus
);
    localparam int SH_W   = (TEXT_BITS > KEY_BITS) ? TEXT_BITS : KEY_BITS;
    localparam int MAX_N  = SH_W / 4;
    localparam int CW     = $clog2(MAX_N) + 1;
    localparam logic [CW-1:0] TEXT_N = CW'(TEXT_BITS / 4);
    localparam logic [CW-1:0] KEY_N  = CW'(KEY_BITS / 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TEXT,
        S_KEY
    } state_t;

    state_t               state_q, state_d;
    logic [SH_W-1:0]      shadow_q, shadow_d;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [TEXT_BITS-1:0] text_q, text_d;
    logic                 text_valid_q, text_valid_d;
    logic [KEY_BITS-1:0]  key_q, key_d;
    logic                 key_valid_q, key_valid_d;
    logic                 decrypt_q, decrypt_d;
    logic                 err_q, err_d;
    logic [1:0]           code_q, code_d;
    logic [4:0]           hex;

`ifdef HEX_FRAME_PARSER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;
`endif

    // {valid, nibble}; a-f and A-F share the low nibble pattern 1..6
    function automatic logic [4:0] hex_nib(input logic [7:0] b);
        logic [4:0] r;
        r = '0;
        unique case (1'b1)
            (b >= 8'h30 && b <= 8'h39): r = {1'b1, b[3:0]};
            (b >= 8'h41 && b <= 8'h46): r = {1'b1, b[3:0] + 4'd9};
            (b >= 8'h61 && b <= 8'h66): r = {1'b1, b[3:0] + 4'd9};
            default:                    r = '0;
        endcase
        return r;
    endfunction

    assign hex     = hex_nib(bus.i_rx_byte);
    assign cnt_inc = cnt_q + CW'(1);

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shadow_q     <= '0;
            cnt_q        <= '0;
            text_q       <= '0;
            text_valid_q <= 1'b0;
            key_q        <= '0;
            key_valid_q  <= 1'b0;
            decrypt_q    <= 1'b0;
            err_q        <= 1'b0;
            code_q       <= 2'd0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            cnt_q        <= cnt_d;
            text_q       <= text_d;
            text_valid_q <= text_valid_d;
            key_q        <= key_d;
            key_valid_q  <= key_valid_d;
            decrypt_q    <= decrypt_d;
            err_q        <= err_d;
            code_q       <= code_d;
        end
    end

`ifdef HEX_FRAME_PARSER_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`endif

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        cnt_d        = cnt_q;
        text_d       = text_q;
        key_d        = key_q;
        decrypt_d    = decrypt_q;
        err_d        = 1'b0;
        code_d       = code_q;
        text_valid_d = text_valid_q && !bus.i_text_ready;
        key_valid_d  = key_valid_q && !bus.i_key_ready;
`ifdef HEX_FRAME_PARSER_TIMEOUT_EN
        tmo_d   = '0;
        tmo_hit = 1'b0;
        if (state_q != S_IDLE && !bus.i_rx_dv) begin
            tmo_d   = tmo_q + TW'(1);
            tmo_hit = (tmo_q == TMO_LAST);
        end
        if (tmo_hit) begin
            tmo_d   = '0;
            state_d = S_IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
            code_d  = 2'd3;
        end
`endif
        if (bus.i_rx_dv) begin
            unique case (state_q)
                S_IDLE: begin
                    unique case (bus.i_rx_byte)
                        8'h4D: begin
                            state_d  = S_TEXT;
                            cnt_d    = '0;
                            shadow_d = '0;
                        end
                        8'h41: begin
                            state_d  = S_KEY;
                            cnt_d    = '0;
                            shadow_d = '0;
                        end
                        8'h45:   decrypt_d = 1'b0;
                        8'h44:   decrypt_d = 1'b1;
                        default: ;
                    endcase
                end
                S_TEXT, S_KEY: begin
                    if (!hex[4]) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end else begin
                        shadow_d = {shadow_q[SH_W-5:0], hex[3:0]};
                        cnt_d    = cnt_inc;
                        if (state_q == S_TEXT && cnt_inc == TEXT_N) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                            // a pending, unaccepted block wins over the new one
                            if (!text_valid_q || bus.i_text_ready) begin
                                text_d       = shadow_d[TEXT_BITS-1:0];
                                text_valid_d = 1'b1;
                            end else begin
                                err_d  = 1'b1;
                                code_d = 2'd2;
                            end
                        end
                        if (state_q == S_KEY && cnt_inc == KEY_N) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                            if (!key_valid_q || bus.i_key_ready) begin
                                key_d       = shadow_d[KEY_BITS-1:0];
                                key_valid_d = 1'b1;
                            end else begin
                                err_d  = 1'b1;
                                code_d = 2'd2;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.o_text       = text_q;
    assign bus.o_text_valid = text_valid_q;
    assign bus.o_key        = key_q;
    assign bus.o_key_valid  = key_valid_q;
    assign bus.o_decrypt    = decrypt_q;
    assign bus.o_err        = err_q;
    assign bus.o_err_code   = code_q;
endmodule

// File: tb/tb_hex_frame_parser.sv
// Directed bench for hex_frame_parser: frames, errors, handshake, mode, reset, timeout.
module tb_hex_frame_parser;
    logic clk;
    logic reset;
    int   total;
    int   passed;

    hex_frame_parser_if #(.TEXT_BITS(128), .KEY_BITS(256)) bus ();

    hex_frame_parser #(
        .TEXT_BITS(128),
        .KEY_BITS(256),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk_i(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            bus.i_rx_dv   = 1'b1;
            bus.i_rx_byte = s[i];
        end
        @(negedge clk);
        bus.i_rx_dv   = 1'b0;
        bus.i_rx_byte = 8'h00;
    endtask

    task automatic pulse_text_ready();
        @(negedge clk);
        bus.i_text_ready = 1'b1;
        @(negedge clk);
        bus.i_text_ready = 1'b0;
    endtask

    task automatic pulse_key_ready();
        @(negedge clk);
        bus.i_key_ready = 1'b1;
        @(negedge clk);
        bus.i_key_ready = 1'b0;
    endtask

    localparam logic [127:0] T1 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] TX = 128'hFFEEDDCCBBAA99887766554433221100;
    localparam logic [127:0] TZ = 128'hFEDCBA9876543210FEDCBA9876543210;
    localparam logic [255:0] K1 =
        256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
    localparam logic [255:0] K2 =
        256'hDEADBEEF0123456789ABCDEF00112233445566778899AABBCCDDEEFF0A1B2C3D;

    initial begin
        bit seen;
        logic [1:0] seen_code;
        total = 0;
        passed = 0;
        reset = 1'b1;
        bus.i_rx_dv = 1'b0;
        bus.i_rx_byte = 8'h00;
        bus.i_text_ready = 1'b0;
        bus.i_key_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_text", bus.o_text, 0);
        chk("rst_tv", bus.o_text_valid, 0);
        chk("rst_key", bus.o_key, 0);
        chk("rst_kv", bus.o_key_valid, 0);
        chk("rst_dec", bus.o_decrypt, 0);
        chk("rst_err", bus.o_err, 0);
        chk("rst_code", bus.o_err_code, 0);
        reset = 1'b0;

        send_str("M0123G");
        chk("bad_err", bus.o_err, 1);
        chk("bad_code", bus.o_err_code, 1);
        chk("bad_tv", bus.o_text_valid, 0);
        chk("bad_text", bus.o_text, 0);
        @(negedge clk);
        chk("bad_pulse", bus.o_err, 0);
        chk("bad_hold", bus.o_err_code, 1);

        send_str("M00112233445566778899aabbccddeeff");
        chk("t1_text", bus.o_text, T1);
        chk("t1_tv", bus.o_text_valid, 1);
        chk("t1_err", bus.o_err, 0);
        repeat (3) @(negedge clk);
        chk("t1_hold", bus.o_text_valid, 1);
        pulse_text_ready();
        chk("t1_drop", bus.o_text_valid, 0);
        chk("t1_stable", bus.o_text, T1);

        send_str("A000102030405060708090a0B0c0D0e0F101112131415161718191a1B1c1D1e1F");
        chk("k1_key", bus.o_key, K1);
        chk("k1_kv", bus.o_key_valid, 1);
        chk("k1_err", bus.o_err, 0);
        pulse_key_ready();
        chk("k1_drop", bus.o_key_valid, 0);

        send_str("Mffeeddccbbaa99887766554433221100");
        chk("ov_x", bus.o_text, TX);
        chk("ov_xv", bus.o_text_valid, 1);
        send_str("M0123456789abcdef0123456789abcdef");
        chk("ov_err", bus.o_err, 1);
        chk("ov_code", bus.o_err_code, 2);
        chk("ov_keep", bus.o_text, TX);
        chk("ov_v", bus.o_text_valid, 1);
        send_str("Mfedcba9876543210fedcba987654321");
        @(negedge clk);
        bus.i_rx_dv = 1'b1;
        bus.i_rx_byte = "0";
        bus.i_text_ready = 1'b1;
        @(negedge clk);
        bus.i_rx_dv = 1'b0;
        bus.i_text_ready = 1'b0;
        chk("rd_text", bus.o_text, TZ);
        chk("rd_v", bus.o_text_valid, 1);
        chk("rd_err", bus.o_err, 0);

        send_str("D");
        chk("mode_d", bus.o_decrypt, 1);
        send_str("E");
        chk("mode_e", bus.o_decrypt, 0);
        send_str("D");
        chk("mode_d2", bus.o_decrypt, 1);

        send_str("A0123456789");
        #2 reset = 1'b1;
        #1;
        chk("mr_text", bus.o_text, 0);
        chk("mr_tv", bus.o_text_valid, 0);
        chk("mr_dec", bus.o_decrypt, 0);
        chk("mr_code", bus.o_err_code, 0);
        @(negedge clk);
        reset = 1'b0;
        send_str("AdeadBEEF0123456789abcdef00112233445566778899aabbccddeeff0a1b2c3d");
        chk("k2_key", bus.o_key, K2);
        chk("k2_kv", bus.o_key_valid, 1);
        pulse_key_ready();

        send_str("A12345");
        seen = 1'b0;
        seen_code = 2'd0;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            if (bus.o_err && !seen) begin
                seen = 1'b1;
                seen_code = bus.o_err_code;
            end
        end
`ifdef HEX_FRAME_PARSER_TIMEOUT_EN
        chk("tmo_seen", seen, 1);
        chk("tmo_code", seen_code, 3);
`else
        chk("tmo_none", seen, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif
        send_str("A000102030405060708090a0B0c0D0e0F101112131415161718191a1B1c1D1e1F");
        chk("tk_key", bus.o_key, K1);
        chk("tk_kv", bus.o_key_valid, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
